// File: rtl/dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-issue controller.
// Holds the controller state encoding, the issue-count encoding produced by
// the pair hazard checker, and the register-address type shared with decode.
package dual_issue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Number of decode slots consumed in one cycle
  localparam logic [1:0] ISS_NONE = 2'd0;
  localparam logic [1:0] ISS_ONE  = 2'd1;
  localparam logic [1:0] ISS_TWO  = 2'd2;

endpackage

// File: rtl/dual_issue_ctrl_hazard.sv
// issue_hazard_chk: combinational pair check for the two decode slots.
// Ports:
//   d0_valid/d1_valid        decode slot occupancy (slot0 older)
//   d0_rs/rt/rd, d1_rs/rt/rd register addresses
//   d0_rfwe/d1_rfwe          slot writes the register file
//   iss_cnt                  instructions that may issue together (0/1/2)
module issue_hazard_chk
  import dual_issue_ctrl_pkg::*;
#(
  parameter int DUAL_EN = 1
) (
  input  logic       d0_valid,
  input  logic       d1_valid,
  input  reg_addr_t  d0_rs,
  input  reg_addr_t  d0_rt,
  input  reg_addr_t  d0_rd,
  input  logic       d0_rfwe,
  input  reg_addr_t  d1_rs,
  input  reg_addr_t  d1_rt,
  input  reg_addr_t  d1_rd,
  input  logic       d1_rfwe,
  output logic [1:0] iss_cnt
);

  logic dep;
  logic waw;

  // Register x0 is hardwired, so writes to it never create a dependency.
  // slot1 can only go out behind slot0, never on its own.
  always_comb begin
    dep = d0_rfwe && (d0_rd != '0) && ((d1_rs == d0_rd) || (d1_rt == d0_rd));
    waw = d0_rfwe && d1_rfwe && (d0_rd != '0) && (d0_rd == d1_rd);
    iss_cnt = ISS_NONE;
    if (d0_valid) begin
      if ((DUAL_EN == 0) || dep || waw || !d1_valid)
        iss_cnt = ISS_ONE;
      else
        iss_cnt = ISS_TWO;
    end
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// dual_issue_ctrl: issue and branch-resolution controller for FAB0/FAB1.
// Registers an issue bundle from the two decode slots, hands out the 1-bit
// ordering numbers, picks the older of two branch results, squashes invalid
// or wrong-path FAB slots through rst_s1 and drives the front-end redirect.
// Ports:
//   clk, rst                 clock, async active-high reset
//   ext_stop                 downstream stall
//   d0_*, d1_*               decode slots (slot0 older)
//   pop                      decode entries consumed this cycle
//   fab0_num, fab1_num       ordering numbers for the FABs
//   fab_rst_s1, fab_stop     per-FAB squash, pipeline hold
//   br0_*, br1_*             FAB branch results
//   redirect, redirect_pc    front-end redirect strobe and target
//   front_flush              flush fetch/decode buffer
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int DUAL_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_stop,
  input  logic            d0_valid,
  input  logic            d1_valid,
  input  logic [4:0]      d0_rs,
  input  logic [4:0]      d0_rt,
  input  logic [4:0]      d0_rd,
  input  logic [4:0]      d1_rs,
  input  logic [4:0]      d1_rt,
  input  logic [4:0]      d1_rd,
  input  logic            d0_rfwe,
  input  logic            d1_rfwe,
  input  logic            d0_is_br,
  output logic [1:0]      pop,
  output logic            fab0_num,
  output logic            fab1_num,
  output logic [1:0]      fab_rst_s1,
  output logic            fab_stop,
  input  logic            br0_flag,
  input  logic            br1_flag,
  input  logic            br0_num,
  input  logic            br1_num,
  input  logic [PC_W-1:0] br0_addr,
  input  logic [PC_W-1:0] br1_addr,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            front_flush
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] iss_valid;
  logic       seq;
  logic       base_num;
  logic [1:0] iss_cnt;
  logic       issue_en;
  logic       br0_ok;
  logic       br1_ok;
  logic       br_hit;
  logic       sel1;
  logic       kill1;

  // A branch in slot0 may still pair with slot1: if it is taken, the
  // arbitration below squashes the younger FAB1 instruction.
  logic unused_is_br;
  assign unused_is_br = d0_is_br;

  issue_hazard_chk #(.DUAL_EN(DUAL_EN)) u_hazard (
    .d0_valid (d0_valid),
    .d1_valid (d1_valid),
    .d0_rs    (d0_rs),
    .d0_rt    (d0_rt),
    .d0_rd    (d0_rd),
    .d0_rfwe  (d0_rfwe),
    .d1_rs    (d1_rs),
    .d1_rt    (d1_rt),
    .d1_rd    (d1_rd),
    .d1_rfwe  (d1_rfwe),
    .iss_cnt  (iss_cnt)
  );

  // Age arbitration: the result whose number matches base_num is older.
  // kill1 fires whenever FAB0 wins while FAB1 holds a younger instruction.
  always_comb begin
    br0_ok = br0_flag & iss_valid[0];
    br1_ok = br1_flag & iss_valid[1];
    br_hit = br0_ok | br1_ok;
    sel1   = br1_ok & (~br0_ok | (br0_num != base_num));
    kill1  = br_hit & ~sel1 & iss_valid[1];
  end

  // Next-state and front-end control. A redirect cycle issues nothing: the
  // decode contents are on the wrong path and are flushed anyway.
  always_comb begin
    state_d     = state_q;
    redirect    = 1'b0;
    redirect_pc = '0;
    front_flush = 1'b0;
    issue_en    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!ext_stop) begin
          if (br_hit) begin
            redirect    = 1'b1;
            redirect_pc = sel1 ? br1_addr : br0_addr;
            front_flush = 1'b1;
            state_d     = ST_FLUSH;
          end else begin
            issue_en = ~rst;
          end
        end
      end
      ST_FLUSH: begin
        front_flush = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pop        = issue_en ? iss_cnt : ISS_NONE;
    fab0_num   = base_num;
    fab1_num   = ~base_num;
    fab_stop   = ext_stop;
    fab_rst_s1 = {2{rst}} | ~iss_valid | {kill1, 1'b0};
  end

  // Issue bundle and sequence number. FLUSH always loads an empty bundle;
  // a stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      iss_valid <= 2'b00;
      seq       <= 1'b0;
      base_num  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) begin
        iss_valid <= 2'b00;
        base_num  <= seq;
      end else if (!ext_stop) begin
        base_num <= seq;
        if (redirect) begin
          iss_valid <= 2'b00;
        end else begin
          iss_valid <= {iss_cnt == ISS_TWO, iss_cnt != ISS_NONE};
          seq       <= seq ^ (iss_cnt == ISS_ONE);
        end
      end
    end
  end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
Issue and branch-resolution controller for the two parallel FAB execution units.
- Each cycle it takes up to two decoded instructions (slot0 older, slot1 younger) from the decode buffer, checks for hazards inside the pair, and registers an issue bundle for FAB0/FAB1.
- It assigns the 1-bit ordering numbers and arbitrates the two branch results by age.
- It squashes wrong-path or invalid slots through each FAB's synchronous rst_s1 input and drives the front-end redirect.

Parameters:
PC_W, 32, PC / branch-address width.
DUAL_EN, 1, 0 forces single issue (slot0 only).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ext_stop  in  1  downstream stall (memory)
d0_valid, d1_valid  in  1 each  decode slot holds an instruction
d0_rs, d0_rt, d0_rd, d1_rs, d1_rt, d1_rd  in  5 each  register addresses
d0_rfwe, d1_rfwe  in  1 each  slot writes the register file
d0_is_br  in  1  slot0 can change PC (branch/JAL/JALR)
pop  out  2  instructions consumed from decode this cycle (0/1/2)
fab0_num, fab1_num  out  1 each  ordering number driven to FAB num_in
fab_rst_s1  out  2  per-FAB synchronous squash (FAB rst_s1)
fab_stop  out  1  FAB pipeline hold
br0_flag, br1_flag  in  1 each  FAB branch_flag
br0_num, br1_num  in  1 each  FAB branch_num
br0_addr, br1_addr  in  PC_W each  FAB branch_address
redirect  out  1  front-end redirect strobe
redirect_pc  out  PC_W  redirect target
front_flush  out  1  flush fetch/decode buffer

Behaviour:
Reset values:
- iss_valid = 00, seq = 0, base_num = 0, state = RUN.
- pop = 0, redirect = 0, redirect_pc = 0, front_flush = 0.
- fab_rst_s1 = 11 while rst is high (combinational OR with rst), so the FAB pipeline registers clear on every clock edge during reset.

Pair hazard (combinational):
- dep = d1 reads d0_rd (rs or rt equal), with d0_rfwe = 1 and d0_rd != 0.
- waw = both slots write the same nonzero rd.
- If DUAL_EN = 0, dep, waw, or d1_valid = 0, issue slot0 only.
- If d0_valid = 0, issue nothing; slot1 never issues alone.

Issue register:
- Updated on clk when the state is RUN and ext_stop = 0.
- iss_valid = {dual, d0_valid}.
- base_num = seq.
- seq advances by the issued count, mod 2.
- pop equals the issued count in the same cycle.

Numbering:
- fab0_num = base_num; fab1_num = ~base_num.
- Slot0 always maps to FAB0.

Branch arbitration (combinational, on the registered issue):
- A branch result is valid only if brX_flag = 1 and iss_valid[X] = 1.
- If both are valid, the older one wins: the one whose brX_num == base_num.
- The winner drives redirect = 1, redirect_pc = brX_addr, front_flush = 1.
- If the winner is FAB0 and iss_valid[1] = 1, kill[1] = 1, squashing the younger instruction.

Squash:
- fab_rst_s1[i] = rst | ~iss_valid[i] | kill[i].
- Invalid or killed slots therefore never write the register file.

State machine:
- RUN → FLUSH on redirect (only when ext_stop = 0).
- In FLUSH, for exactly one cycle:
  - issue registers load invalid, pop = 0
  - redirect = 0
  - front_flush = 1, held one more cycle
- FLUSH → RUN unconditionally.

Stall (ext_stop = 1):
- fab_stop = 1, pop = 0, redirect = 0; issue registers and seq hold.
- A branch result present under stall fires on the first unstalled cycle, exactly once.

Redirect with ext_stop deasserting in the same cycle: the redirect is taken and the state goes to FLUSH.

Asynchronous reset mid-operation: all state clears immediately; no redirect is emitted.

Decomposition:
- Shared def.vh gets the state encodings (ST_RUN, ST_FLUSH) and the issue-count encodings.
- Existing DATA_BUS and REG_ADDR_BUS definitions are reused.
- One sub-module: issue_hazard_chk, combinational pair dep/waw detection producing the issue count.

Test Plan:
- Independent pair: d0 = add x1, d1 = add x2, both valid, seq = 0 → pop = 2, next cycle iss_valid = 11, fab0_num = 0, fab1_num = 1, fab_rst_s1 = 00.
- RAW in pair: d0 rd = x5, d1 rs = x5 → pop = 1, iss_valid = 01, fab_rst_s1 = 10; next cycle the former d1 issues with fab0_num = 1.
- Older branch taken: iss_valid = 11, br0_flag = 1, br0_addr = 0x100 → redirect = 1, redirect_pc = 0x100, fab_rst_s1[1] = 1, then one FLUSH cycle with pop = 0.
- Both branches flagged, base_num = 1, br1_num = 1, br1_addr = 0x200 → redirect_pc = 0x200 (FAB1 is older), no kill of FAB0.
- ext_stop = 1 for 3 cycles with br0_flag pending → fab_stop = 1, pop = 0, no redirect; on release, exactly one redirect pulse.
- Assert rst during FLUSH → all outputs return to reset values asynchronously, fab_rst_s1 = 11; after release, state = RUN and seq = 0.
